// File: rtl/byte_decode_loader.sv
`timescale 1ns/1ps
// Byte-stream loader: gathers N_BYTES = 32*D encoded bytes (little-endian) into
// one block for the byte decoder, with a FILL/FULL handshake and sync flush.
module byte_decode_loader #(
    parameter  int D       = 12,
    localparam int N_BYTES = 32 * D,
    localparam int CW      = $clog2(N_BYTES + 1)
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    flush_i,
    input  logic [7:0]              byte_i,
    input  logic                    byte_valid_i,
    output logic                    byte_ready_o,
    output logic [N_BYTES-1:0][7:0] b_o,
    output logic                    b_valid_o,
    input  logic                    b_ready_i,
    output logic [CW-1:0]           count_o
);

    localparam int AW = $clog2(N_BYTES);

    if (D < 1 || D > 12) begin : g_bad_d
        $error("byte_decode_loader: D must be in 1..12");
    end

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } state_e;

    state_e                  state_q, state_d;
    logic [CW-1:0]           count_q, count_d;
    logic [N_BYTES-1:0][7:0] blk_q;
    logic [AW-1:0]           wr_idx;
    logic                    wr_en;
    logic                    last_byte;

    // Handshake outputs decode straight from the state register.
    assign byte_ready_o = (state_q == FILL);
    assign b_valid_o    = (state_q == FULL);
    assign count_o      = count_q;
    assign b_o          = blk_q;

    assign wr_idx    = count_q[AW-1:0];
    assign wr_en     = byte_valid_i && (state_q == FILL) && !flush_i;
    assign last_byte = (count_q == CW'(N_BYTES - 1));

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path
        // through the branches below can leave it unassigned and infer a latch.
        state_d = state_q;
        count_d = count_q;
        if (flush_i) begin
            state_d = FILL;
            count_d = '0;
        end else begin
            unique case (state_q)
                FILL: begin
                    if (byte_valid_i) begin
                        count_d = count_q + CW'(1);
                        if (last_byte) state_d = FULL;
                    end
                end
                FULL: begin
                    if (b_ready_i) begin
                        state_d = FILL;
                        count_d = '0;
                    end
                end
                default: begin
                    state_d = FILL;
                    count_d = '0;
                end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples its inputs as they were before this edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= FILL;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // NOTE: the block storage is deliberately reset to zero so the decoder
    // never sees undefined bytes; it is never cleared otherwise, only overwritten.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            blk_q <= '0;
        end else if (wr_en) begin
            blk_q[wr_idx] <= byte_i;
        end
    end

endmodule

// File: tb/tb_byte_decode_loader.sv
`timescale 1ns/1ps
// Directed + randomized bench for byte_decode_loader at D=1, D=4 and D=12,
// checked against a byte-array model of the loader's block/count behaviour.
module tb_byte_decode_loader;

    localparam int N1  = 32;
    localparam int N4  = 128;
    localparam int N12 = 384;
    localparam int C1  = $clog2(N1 + 1);
    localparam int C4  = $clog2(N4 + 1);
    localparam int C12 = $clog2(N12 + 1);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic                f1, v1, r1, br1, bv1;
    logic [7:0]          by1;
    logic [N1-1:0][7:0]  b1;
    logic [C1-1:0]       c1;

    logic                f4, v4, r4, br4, bv4;
    logic [7:0]          by4;
    logic [N4-1:0][7:0]  b4;
    logic [C4-1:0]       c4;

    logic                f12, v12, r12, br12, bv12;
    logic [7:0]          by12;
    logic [N12-1:0][7:0] b12;
    logic [C12-1:0]      c12;

    byte_decode_loader #(.D(1)) u_d1 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(f1), .byte_i(by1), .byte_valid_i(v1),
        .byte_ready_o(br1), .b_o(b1), .b_valid_o(bv1), .b_ready_i(r1), .count_o(c1)
    );
    byte_decode_loader #(.D(4)) u_d4 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(f4), .byte_i(by4), .byte_valid_i(v4),
        .byte_ready_o(br4), .b_o(b4), .b_valid_o(bv4), .b_ready_i(r4), .count_o(c4)
    );
    byte_decode_loader #(.D(12)) u_d12 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(f12), .byte_i(by12), .byte_valid_i(v12),
        .byte_ready_o(br12), .b_o(b12), .b_valid_o(bv12), .b_ready_i(r12), .count_o(c12)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compares a whole block, reporting the lowest differing byte (byte 0 if none).
    task automatic check_bytes(input string tag, input logic [3071:0] obs,
                               input logic [3071:0] exp, input int n);
        int k = 0;
        for (int i = n - 1; i >= 0; i--)
            if (obs[i*8 +: 8] !== exp[i*8 +: 8]) k = i;
        check($sformatf("%s[%0d]", tag, k), 32'(obs[k*8 +: 8]), 32'(exp[k*8 +: 8]));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Model state: expected block bytes per instance plus D=4 count/full.
    logic [3071:0] e1, e4, e12;
    int            cnt4;
    bit            full4;
    int            early;
    int            bad;
    logic [3071:0] flat;
    logic [7:0]    tmp;

    initial begin
        {f1, v1, r1, by1}     = '0;
        {f4, v4, r4, by4}     = '0;
        {f12, v12, r12, by12} = '0;
        e1 = '0; e4 = '0; e12 = '0;

        // Reset state
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_count", 32'(c12), 32'd0);
        check("rst_b_valid", 32'(bv12), 32'd0);
        check("rst_byte_ready", 32'(br12), 32'd1);
        check_bytes("rst_b", 3072'(b12), e12, N12);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_byte_ready", 32'(br12), 32'd1);
        check("post_rst_b_valid", 32'(bv12), 32'd0);

        // D=1: 0x00..0x1F back-to-back, downstream always ready
        early = 0;
        r1 = 1'b1;
        for (int i = 0; i < N1; i++) begin
            by1 = 8'(i);
            v1  = 1'b1;
            if (bv1 !== 1'b0) early++;
            @(negedge clk);
            e1[i*8 +: 8] = 8'(i);
        end
        v1 = 1'b0;
        check("d1_valid_during_fill", 32'(early), 32'd0);
        check("d1_valid_rise", 32'(bv1), 32'd1);
        check("d1_ready_full", 32'(br1), 32'd0);
        check("d1_count_full", 32'(c1), 32'(N1));
        check_bytes("d1_b", 3072'(b1), e1, N1);
        @(negedge clk);
        check("d1_valid_one_cycle", 32'(bv1), 32'd0);
        check("d1_count_after_hs", 32'(c1), 32'd0);

        // D=1: flush while FULL
        r1 = 1'b0;
        for (int i = 0; i < N1; i++) begin
            by1 = 8'(i ^ 8'h5A);
            v1  = 1'b1;
            @(negedge clk);
            e1[i*8 +: 8] = 8'(i ^ 8'h5A);
        end
        v1 = 1'b0;
        check("d1_full_again", 32'(bv1), 32'd1);
        f1 = 1'b1;
        @(negedge clk);
        f1 = 1'b0;
        check("d1_flush_full_valid", 32'(bv1), 32'd0);
        check("d1_flush_full_count", 32'(c1), 32'd0);
        check_bytes("d1_flush_keeps_b", 3072'(b1), e1, N1);

        // D=4: random valid/ready against the block model
        cnt4  = 0;
        full4 = 1'b0;
        for (int cyc = 0; cyc < 1200; cyc++) begin
            v4  = 1'($urandom_range(0, 1));
            by4 = 8'($urandom);
            r4  = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (full4) begin
                if (r4) begin
                    full4 = 1'b0;
                    cnt4  = 0;
                end
            end else if (v4) begin
                e4[cnt4*8 +: 8] = by4;
                cnt4++;
                if (cnt4 == N4) full4 = 1'b1;
            end
            check("d4_count", 32'(c4), 32'(cnt4));
            check("d4_b_valid", 32'(bv4), 32'(full4));
            check("d4_byte_ready", 32'(br4), 32'(!full4));
            if (full4) check_bytes("d4_b_full", 3072'(b4), e4, N4);
        end
        v4 = 1'b0;
        r4 = 1'b0;
        check_bytes("d4_b_end", 3072'(b4), e4, N4);

        // D=12: 384 x 0xFF, downstream stalled, extra valid pulses while FULL
        for (int i = 0; i < N12; i++) begin
            by12 = 8'hFF;
            v12  = 1'b1;
            @(negedge clk);
            e12[i*8 +: 8] = 8'hFF;
        end
        v12 = 1'b0;
        check("d12_full_valid", 32'(bv12), 32'd1);
        check("d12_full_ready", 32'(br12), 32'd0);
        check("d12_full_count", 32'(c12), 32'(N12));
        check_bytes("d12_b_ff", 3072'(b12), e12, N12);

        flat = 3072'(b12);
        bad  = 0;
        for (int i = 0; i < 256; i++)
            if ((int'(flat[i*12 +: 12]) % 3329) != 766) bad++;
        check("decode_coef0", 32'(int'(flat[11:0]) % 3329), 32'd766);
        check("decode_bad_coefs", 32'(bad), 32'd0);

        for (int i = 0; i < 10; i++) begin
            v12  = 1'(i % 2);
            by12 = 8'h00;
            @(negedge clk);
            check("d12_stall_ready", 32'(br12), 32'd0);
            check("d12_stall_valid", 32'(bv12), 32'd1);
            check("d12_stall_count", 32'(c12), 32'(N12));
            check_bytes("d12_stall_b", 3072'(b12), e12, N12);
        end
        v12 = 1'b0;
        r12 = 1'b1;
        @(negedge clk);
        r12 = 1'b0;
        check("d12_hs_count", 32'(c12), 32'd0);
        check("d12_hs_valid", 32'(bv12), 32'd0);
        check("d12_hs_ready", 32'(br12), 32'd1);
        check_bytes("d12_hs_keeps_b", 3072'(b12), e12, N12);

        // D=12: flush coincident with a valid byte at count 200
        for (int i = 0; i < 200; i++) begin
            tmp  = 8'($urandom);
            by12 = tmp;
            v12  = 1'b1;
            @(negedge clk);
            e12[i*8 +: 8] = tmp;
        end
        check("d12_count_200", 32'(c12), 32'd200);
        f12  = 1'b1;
        v12  = 1'b1;
        by12 = 8'hAB;
        @(negedge clk);
        f12 = 1'b0;
        v12 = 1'b0;
        check("d12_flush_count", 32'(c12), 32'd0);
        check("d12_flush_ready", 32'(br12), 32'd1);
        check_bytes("d12_flush_drops", 3072'(b12), e12, N12);
        by12 = 8'h5A;
        v12  = 1'b1;
        @(negedge clk);
        v12 = 1'b0;
        e12[7:0] = 8'h5A;
        check("d12_after_flush_count", 32'(c12), 32'd1);
        check_bytes("d12_after_flush_b0", 3072'(b12), e12, N12);

        // D=12: asynchronous reset mid-clock at count 100
        for (int i = 1; i < 100; i++) begin
            tmp  = 8'($urandom);
            by12 = tmp;
            v12  = 1'b1;
            @(negedge clk);
            e12[i*8 +: 8] = tmp;
        end
        v12 = 1'b0;
        check("d12_count_100", 32'(c12), 32'd100);
        #2 rst_n = 1'b0;
        #1;
        e12 = '0;
        check("arst_count", 32'(c12), 32'd0);
        check("arst_valid", 32'(bv12), 32'd0);
        check("arst_ready", 32'(br12), 32'd1);
        check_bytes("arst_b", 3072'(b12), e12, N12);
        @(negedge clk);
        rst_n = 1'b1;
        by12  = 8'h77;
        v12   = 1'b1;
        @(negedge clk);
        v12 = 1'b0;
        e12[7:0] = 8'h77;
        check("arst_first_byte_count", 32'(c12), 32'd1);
        check_bytes("arst_first_byte_b0", 3072'(b12), e12, N12);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
